// File: rtl/lc3b_types.sv
// Shared types for the L2 arbiter: bus widths, FSM states and grant encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] cache_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_t;

endpackage

// File: rtl/l2_arb_ctrl_arb_pick.sv
// Grant selection: D-cache wins by default, I-cache wins once it has been
// starved for STARVE_LIMIT consecutive D grants.
module arb_pick
    import lc3b_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       i_req_i,
    input  logic       i_req_d,
    input  logic [3:0] i_starve_cnt,
    output grant_t     o_grant
);

    logic w_i_starved;

    assign w_i_starved = i_req_i && (i_starve_cnt == 4'(STARVE_LIMIT));

    // Priority pick between the two requesters
    always_comb begin
        o_grant = GNT_NONE;
        if (i_req_d && !w_i_starved) begin
            o_grant = GNT_D;
        end else if (i_req_i) begin
            o_grant = GNT_I;
        end
    end

endmodule

// File: rtl/l2_arb_ctrl.sv
// Arbitrates I-cache fills and D-cache reads/writebacks onto a single L2 port.
// All l2_* outputs come from registers latched at grant time, so requester
// inputs may change freely while a transaction is in flight.
module l2_arb_ctrl
    import lc3b_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_req_read,
    input  lc3b_word  i_req_address,
    input  logic      d_req_read,
    input  logic      d_req_write,
    input  lc3b_word  d_req_address,
    input  cache_line d_req_wdata,
    output logic      i_resp,
    output cache_line i_rdata,
    output logic      d_resp,
    output cache_line d_rdata,
    output logic      l2_read,
    output logic      l2_write,
    output lc3b_word  l2_address,
    output cache_line l2_wdata,
    input  cache_line l2_rdata,
    input  logic      l2_resp,
    output logic      busy,
    output logic      proto_err
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    grant_t     w_grant;
    logic       w_d_req;
    logic       w_serving;
    logic [3:0] r_starve_cnt;
    lc3b_word   r_addr;
    cache_line  r_wdata;
    logic       r_write;
    logic       r_owner_d;
    cache_line  r_i_rdata;
    cache_line  r_d_rdata;
    logic       r_proto_err;

    assign w_d_req   = d_req_read || d_req_write;
    assign w_serving = (r_state == SERVE_I) || (r_state == SERVE_D);

    arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb_pick (
        .i_req_i      (i_req_read),
        .i_req_d      (w_d_req),
        .i_starve_cnt (r_starve_cnt),
        .o_grant      (w_grant)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: grant from IDLE, wait for L2, one DONE cycle before re-arbitration
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant == GNT_I) begin
                    w_next_state = SERVE_I;
                end else if (w_grant == GNT_D) begin
                    w_next_state = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (l2_resp) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Holding registers, starvation counter, read-data capture and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_write      <= 1'b0;
            r_owner_d    <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                if (w_grant == GNT_I) begin
                    r_addr       <= i_req_address;
                    r_wdata      <= '0;
                    r_write      <= 1'b0;
                    r_owner_d    <= 1'b0;
                    r_starve_cnt <= '0;
                end else if (w_grant == GNT_D) begin
                    r_addr    <= d_req_address;
                    r_wdata   <= d_req_wdata;
                    // Simultaneous read+write resolves to the writeback
                    r_write   <= d_req_write;
                    r_owner_d <= 1'b1;
                    if (d_req_read && d_req_write) begin
                        r_proto_err <= 1'b1;
                    end
                    if (i_req_read && (r_starve_cnt < 4'(STARVE_LIMIT))) begin
                        r_starve_cnt <= r_starve_cnt + 4'd1;
                    end
                end
            end
            if (l2_resp) begin
                if (r_state == SERVE_I) begin
                    r_i_rdata <= l2_rdata;
                end else if ((r_state == SERVE_D) && !r_write) begin
                    r_d_rdata <= l2_rdata;
                end else if (!w_serving) begin
                    r_proto_err <= 1'b1;
                end
            end
        end
    end

    assign busy       = (r_state != IDLE);
    assign l2_read    = w_serving && !r_write;
    assign l2_write   = w_serving && r_write;
    assign l2_address = r_addr;
    assign l2_wdata   = r_wdata;
    assign i_resp     = (r_state == DONE) && !r_owner_d;
    assign d_resp     = (r_state == DONE) && r_owner_d;
    assign i_rdata    = r_i_rdata;
    assign d_rdata    = r_d_rdata;
    assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_l2_arb_ctrl.sv
// Bench for l2_arb_ctrl: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_l2_arb_ctrl;

    localparam int LIMIT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_req_read = 1'b0;
    logic [15:0]  i_req_address = '0;
    logic         d_req_read = 1'b0;
    logic         d_req_write = 1'b0;
    logic [15:0]  d_req_address = '0;
    logic [127:0] d_req_wdata = '0;
    logic         i_resp;
    logic [127:0] i_rdata;
    logic         d_resp;
    logic [127:0] d_rdata;
    logic         l2_read;
    logic         l2_write;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata;
    logic [127:0] l2_rdata = '0;
    logic         l2_resp = 1'b0;
    logic         busy;
    logic         proto_err;

    l2_arb_ctrl #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_read(i_req_read), .i_req_address(i_req_address),
        .d_req_read(d_req_read), .d_req_write(d_req_write),
        .d_req_address(d_req_address), .d_req_wdata(d_req_wdata),
        .i_resp(i_resp), .i_rdata(i_rdata), .d_resp(d_resp), .d_rdata(d_rdata),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int mode  = 0;   // 0: bench drives l2_resp by hand, 1: random L2, 2: L2 answers at once

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        chk(nm, {127'd0, act}, {127'd0, exp});
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        chk(nm, {112'd0, act}, {112'd0, exp});
    endtask

    // ---------------- reference model (one open transaction at a time) ------
    bit           m_open;        // L2 command outstanding
    bit           m_is_i;
    bit           m_wr;
    logic [15:0]  m_addr;
    logic [127:0] m_wdata;
    int           m_owner;       // 1 = I, 2 = D : responder being answered this cycle
    int           m_starve;      // D grants given while I was waiting since last I grant
    logic [127:0] m_i_rdata;
    logic [127:0] m_d_rdata;
    bit           m_err;
    bit           m_dreq;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_open = 0; m_is_i = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
            m_owner = 0; m_starve = 0; m_i_rdata = '0; m_d_rdata = '0; m_err = 0;
        end else if (m_owner != 0) begin
            m_owner = 0;
            if (l2_resp) m_err = 1;
        end else if (m_open) begin
            if (l2_resp) begin
                if (m_is_i) m_i_rdata = l2_rdata;
                else if (!m_wr) m_d_rdata = l2_rdata;
                m_open  = 0;
                m_owner = m_is_i ? 1 : 2;
            end
        end else begin
            if (l2_resp) m_err = 1;
            m_dreq = d_req_read || d_req_write;
            if (m_dreq && !(i_req_read && m_starve == LIMIT)) begin
                m_open = 1; m_is_i = 0; m_wr = d_req_write;
                m_addr = d_req_address; m_wdata = d_req_wdata;
                if (d_req_read && d_req_write) m_err = 1;
                if (i_req_read && m_starve < LIMIT) m_starve = m_starve + 1;
            end else if (i_req_read) begin
                m_open = 1; m_is_i = 1; m_wr = 0; m_addr = i_req_address;
                m_starve = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk_b("busy", busy, m_open || (m_owner != 0));
        chk_b("l2_read", l2_read, m_open && !m_wr);
        chk_b("l2_write", l2_write, m_open && m_wr);
        chk_b("i_resp", i_resp, m_owner == 1);
        chk_b("d_resp", d_resp, m_owner == 2);
        chk("i_rdata", i_rdata, m_i_rdata);
        chk("d_rdata", d_rdata, m_d_rdata);
        chk_b("proto_err", proto_err, m_err);
        if (m_open) chk16("l2_address", l2_address, m_addr);
        if (m_open && m_wr) chk("l2_wdata", l2_wdata, m_wdata);
    end

    // Automatic L2 responder
    always @(negedge clk) begin
        if (mode == 1) begin
            l2_resp  = m_open ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 63) == 0);
            l2_rdata = {$urandom, $urandom, $urandom, $urandom};
        end else if (mode == 2) begin
            l2_resp  = m_open;
            l2_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus -------------------------------------------------
    localparam logic [127:0] LINE_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] LINE_B = 128'hB0B0_B1B1_B2B2_B3B3_B4B4_B5B5_B6B6_B7B7;
    localparam logic [127:0] LINE_C = 128'hC0FF_EE00_C0FF_EE00_C0FF_EE00_C0FF_EE00;
    localparam logic [127:0] LINE_R = 128'h5555_AAAA_5555_AAAA_1234_5678_9ABC_DEF0;

    logic [127:0] seq;
    logic [127:0] exp_seq;
    int           n_seen;
    int           r;

    initial begin
        repeat (3) @(negedge clk);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_l2_read", l2_read, 1'b0);
        chk_b("rst_proto_err", proto_err, 1'b0);
        chk("rst_i_rdata", i_rdata, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single I read of 0x1230, L2 answers at cycle 3
        i_req_read = 1'b1; i_req_address = 16'h1230;             // cycle 0
        @(negedge clk);                                            // cycle 1
        chk_b("i_read_cmd_c1", l2_read, 1'b1);
        chk16("i_read_addr", l2_address, 16'h1230);
        i_req_read = 1'b0;
        @(negedge clk);                                            // cycle 2
        @(negedge clk);                                            // cycle 3
        chk_b("i_resp_early", i_resp, 1'b0);
        l2_resp = 1'b1; l2_rdata = LINE_A;
        @(negedge clk);                                            // cycle 4
        chk_b("i_resp_c4", i_resp, 1'b1);
        chk("i_rdata_A", i_rdata, LINE_A);
        l2_resp = 1'b0;
        @(negedge clk);                                            // cycle 5
        chk_b("i_resp_one_cycle", i_resp, 1'b0);
        chk_b("idle_after_i", busy, 1'b0);

        // D write 0x4440 with data B; inputs change during the access
        d_req_write = 1'b1; d_req_address = 16'h4440; d_req_wdata = LINE_B;
        @(negedge clk);
        chk_b("d_write_cmd", l2_write, 1'b1);
        chk("d_write_data", l2_wdata, LINE_B);
        d_req_write = 1'b0; d_req_address = 16'hBEEF; d_req_wdata = ~LINE_B;
        @(negedge clk);
        chk16("d_addr_held", l2_address, 16'h4440);
        chk("d_wdata_held", l2_wdata, LINE_B);
        @(negedge clk);
        l2_resp = 1'b1; l2_rdata = LINE_C;
        @(negedge clk);
        chk_b("d_resp_write", d_resp, 1'b1);
        chk("d_rdata_untouched", d_rdata, 128'd0);
        l2_resp = 1'b0;
        @(negedge clk);
        chk_b("d_resp_one_cycle", d_resp, 1'b0);

        // Both requesters held: expect D,D,D,D,I repeating
        seq = '0; n_seen = 0;
        exp_seq = 128'("DDDDIDDDDI");
        i_req_read = 1'b1; d_req_read = 1'b1;
        mode = 2;
        for (int c = 0; c < 200 && n_seen < 10; c++) begin
            @(negedge clk);
            if (i_resp) begin seq = {seq[119:0], 8'h49}; n_seen++; end
            if (d_resp) begin seq = {seq[119:0], 8'h44}; n_seen++; end
        end
        i_req_read = 1'b0; d_req_read = 1'b0;
        chk("grant_count", 128'(n_seen), 128'd10);
        chk("grant_order", seq, exp_seq);
        @(negedge clk);
        mode = 0; l2_resp = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while an I read waits; D request pending across reset
        i_req_read = 1'b1; i_req_address = 16'h2000;
        @(negedge clk);
        chk_b("rst_mid_cmd", l2_read, 1'b1);
        d_req_read = 1'b1; d_req_address = 16'h3330;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_b("async_busy", busy, 1'b0);
        chk_b("async_l2_read", l2_read, 1'b0);
        chk_b("async_l2_write", l2_write, 1'b0);
        chk16("async_l2_addr", l2_address, 16'h0000);
        chk_b("async_i_resp", i_resp, 1'b0);
        chk("async_i_rdata", i_rdata, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_b("post_rst_d_first", l2_read, 1'b1);
        chk16("post_rst_d_addr", l2_address, 16'h3330);
        i_req_read = 1'b0; d_req_read = 1'b0;
        l2_resp = 1'b1; l2_rdata = LINE_R;
        @(negedge clk);
        chk_b("post_rst_d_resp", d_resp, 1'b1);
        chk("post_rst_d_rdata", d_rdata, LINE_R);
        l2_resp = 1'b0;
        @(negedge clk);

        // Spurious l2_resp in IDLE, then read+write together
        l2_resp = 1'b1; l2_rdata = LINE_C;
        @(negedge clk);
        l2_resp = 1'b0;
        chk_b("spurious_err", proto_err, 1'b1);
        chk_b("spurious_ignored", busy, 1'b0);
        d_req_read = 1'b1; d_req_write = 1'b1; d_req_address = 16'h5550; d_req_wdata = LINE_A;
        @(negedge clk);
        chk_b("rw_is_write", l2_write, 1'b1);
        chk_b("rw_not_read", l2_read, 1'b0);
        d_req_read = 1'b0; d_req_write = 1'b0;
        l2_resp = 1'b1; l2_rdata = LINE_B;
        @(negedge clk);
        chk_b("rw_resp", d_resp, 1'b1);
        chk("rw_d_rdata_kept", d_rdata, LINE_R);
        l2_resp = 1'b0;
        repeat (3) @(negedge clk);
        chk_b("err_sticky", proto_err, 1'b1);

        // Randomized traffic with occasional asynchronous resets
        mode = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            i_req_read    = 1'($urandom_range(0, 1));
            i_req_address = 16'($urandom);
            r             = int'($urandom_range(0, 15));
            d_req_read    = (r >= 4 && r <= 9) || (r == 15);
            d_req_write   = (r >= 10);
            d_req_address = 16'($urandom);
            d_req_wdata   = {$urandom, $urandom, $urandom, $urandom};
            if (i % 700 == 699) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        mode = 0;
        @(negedge clk);
        i_req_read = 1'b0; d_req_read = 1'b0; d_req_write = 1'b0; l2_resp = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk_b("final_err_clear", proto_err, 1'b0);
        chk_b("final_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/l2_arb_ctrl.md
L2_ARB_CTRL -- requirements
Module: l2_arb_ctrl

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, number of consecutive D grants allowed while an I request waits (range 1-15).
REQ-002 SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-003 SHALL have port: clk  in  1  rising-edge clock.
REQ-004 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: i_req_read  in  1 (I-cache line fill request); i_req_address  in  lc3b_word (line address).
REQ-006 SHALL have ports: d_req_read  in  1; d_req_write  in  1 (D-cache writeback); d_req_address  in  lc3b_word; d_req_wdata  in  cache_line.
REQ-007 SHALL have ports: i_resp  out  1; i_rdata  out  cache_line; d_resp  out  1; d_rdata  out  cache_line.
REQ-008 SHALL have ports: l2_read  out  1; l2_write  out  1; l2_address  out  lc3b_word; l2_wdata  out  cache_line; l2_rdata  in  cache_line; l2_resp  in  1.
REQ-009 SHALL have ports: busy  out  1 (transaction in flight); proto_err  out  1 (sticky protocol violation flag).

Function
REQ-010 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, DONE.
REQ-011 IDLE, no request: SHALL remain in IDLE.
REQ-012 IDLE, D request only: SHALL go to SERVE_D.
REQ-013 IDLE, I request only: SHALL go to SERVE_I.
REQ-014 IDLE, both requesting: SHALL go to SERVE_D unless starve_cnt == STARVE_LIMIT, in which case SHALL go to SERVE_I.
REQ-015 On each grant SHALL latch address, op (read/write) and wdata into holding registers; l2_* outputs SHALL be driven only from these registers.
REQ-016 SHALL assert l2_read or l2_write only in SERVE_I/SERVE_D, starting the cycle after the grant decision and held constant until l2_resp.
REQ-017 SERVE_x with l2_resp=1: SHALL capture l2_rdata into x_rdata (reads only) and go to DONE.
REQ-018 SERVE_x with l2_resp=0: SHALL remain in SERVE_x.
REQ-019 SHALL assert x_resp for exactly one cycle, during DONE, for the served requester only; x_rdata SHALL be valid in that cycle.
REQ-020 DONE SHALL always go to IDLE; the extra cycle guarantees a requester's stale request is dropped before re-arbitration.
REQ-021 Latency: request sampled in IDLE at cycle 0 -> l2 command at cycle 1 -> l2_resp at cycle k -> x_resp at cycle k+1 -> next grant decision no earlier than cycle k+2.
REQ-022 starve_cnt (4 bits) SHALL increment on each D grant while i_req_read=1, saturating at STARVE_LIMIT.
REQ-023 starve_cnt SHALL clear on every I grant.
REQ-024 d_req_read and d_req_write both high at grant SHALL be treated as a write and SHALL set proto_err.
REQ-025 l2_resp outside SERVE_x SHALL be ignored and SHALL set proto_err.
REQ-026 x_rdata SHALL hold its value between captures; write transactions SHALL NOT alter d_rdata.
REQ-027 busy SHALL be 1 in SERVE_I, SERVE_D and DONE.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE and clear starve_cnt, holding registers, i_rdata, d_rdata, all resp/l2 strobes, busy and proto_err to 0.
REQ-029 Reset mid-transaction SHALL abandon the L2 access, with no resp issued; after release the first IDLE cycle SHALL re-arbitrate.

Structure
REQ-030 lc3b_word (16 b), cache_line (128 b) and the FSM state enum SHALL reside in package lc3b_types.
REQ-031 Grant selection logic SHALL be a sub-module arb_pick (inputs: requests, starve_cnt; output: grant encoding).

Verification
REQ-032 Single I read 0x1230, L2 responds after 3 cycles with line A -> l2_read at cycle 1, i_resp one cycle at cycle 4, i_rdata=A.
REQ-033 D write 0x4440 with data B -> l2_write=1, l2_wdata=B held until l2_resp; d_resp pulses once; d_rdata unchanged.
REQ-034 I and D requests held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I repeating.
REQ-035 Change d_req_address/wdata during SERVE_D -> l2_address/l2_wdata remain at latched values.
REQ-036 rst_n low in SERVE_I mid-wait -> all outputs 0 immediately, no i_resp; after release a pending D request is granted first.
REQ-037 d_req_read=d_req_write=1, and a spurious l2_resp in IDLE -> write performed, proto_err=1 and sticky until reset.
